demux_filas_matriz_c: RTL and testbench

- Row collector for the 4x4 complex matrix multiplier; it performs the inverse of the row selection on matrix A.
- Accepts one result row of four complex elements per handshake and writes it into an internal 4x4 complex register bank (matrix C), filling row 0 through row 3 in order.
- Once all four rows are written, it presents the complete matrix on parallel outputs and signals completion to the control FSM.

---
 rtl/demux_filas_matriz_c_if.sv | 18 +
 rtl/demux_filas_matriz_c.sv | 114 +++++++++++
 tb/tb_demux_filas_matriz_c.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/demux_filas_matriz_c_if.sv
// demux_filas_matriz_c_if: row handshake and element bus from the producer into the C-matrix collector
interface demux_filas_matriz_c_if #(parameter int Width = 8);
  logic in_valid;
  logic in_ready;
  logic [1:0] row_idx;
  logic signed [Width-1:0] inx1real, inx1imag, inx2real, inx2imag;
  logic signed [Width-1:0] inx3real, inx3imag, inx4real, inx4imag;
  modport master (
    output in_valid, row_idx, inx1real, inx1imag, inx2real, inx2imag,
           inx3real, inx3imag, inx4real, inx4imag,
    input  in_ready
  );
  modport slave (
    input  in_valid, row_idx, inx1real, inx1imag, inx2real, inx2imag,
           inx3real, inx3imag, inx4real, inx4imag,
    output in_ready
  );
endinterface

// File: rtl/demux_filas_matriz_c.sv
// demux_filas_matriz_c: collects four complex result rows into the 4x4 C bank (ROW_INDEX_CHECK_EN enables row-tag check)
module demux_filas_matriz_c #(
  parameter int Width = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  demux_filas_matriz_c_if.slave row,
  output logic signed [Width-1:0] out11real, out11imag, out12real, out12imag,
  output logic signed [Width-1:0] out13real, out13imag, out14real, out14imag,
  output logic signed [Width-1:0] out21real, out21imag, out22real, out22imag,
  output logic signed [Width-1:0] out23real, out23imag, out24real, out24imag,
  output logic signed [Width-1:0] out31real, out31imag, out32real, out32imag,
  output logic signed [Width-1:0] out33real, out33imag, out34real, out34imag,
  output logic signed [Width-1:0] out41real, out41imag, out42real, out42imag,
  output logic signed [Width-1:0] out43real, out43imag, out44real, out44imag,
  output logic [1:0] row_cnt,
  output logic busy,
  output logic matrix_valid,
  output logic done,
  output logic err
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] FULL = 2'd2;
  logic [1:0] state;
  logic signed [Width-1:0] c_re [4][4];
  logic signed [Width-1:0] c_im [4][4];
  logic idx_ok;
`ifdef ROW_INDEX_CHECK_EN
  assign idx_ok = row.row_idx == row_cnt;
`else
  assign idx_ok = 1'b1;
`endif
  assign row.in_ready  = state == FILL;
  assign busy          = state == FILL;
  assign matrix_valid  = state == FULL;
  // start clears and arms; accepted rows are copied into the next bank row until the fourth completes the matrix
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      row_cnt <= 2'd0;
      done    <= 1'b0;
      err     <= 1'b0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          c_re[r][c] <= '0;
          c_im[r][c] <= '0;
        end
    end else begin
      done <= 1'b0;
      if (start) begin
        state   <= FILL;
        row_cnt <= 2'd0;
        err     <= 1'b0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) begin
            c_re[r][c] <= '0;
            c_im[r][c] <= '0;
          end
      end else if (state == FILL && row.in_valid) begin
        if (!idx_ok) begin
          err <= 1'b1;
        end else begin
          c_re[row_cnt][0] <= row.inx1real;
          c_im[row_cnt][0] <= row.inx1imag;
          c_re[row_cnt][1] <= row.inx2real;
          c_im[row_cnt][1] <= row.inx2imag;
          c_re[row_cnt][2] <= row.inx3real;
          c_im[row_cnt][2] <= row.inx3imag;
          c_re[row_cnt][3] <= row.inx4real;
          c_im[row_cnt][3] <= row.inx4imag;
          row_cnt <= row_cnt + 2'd1;
          if (row_cnt == 2'd3) begin
            state <= FULL;
            done  <= 1'b1;
          end
        end
      end
    end
  end
  assign out11real = c_re[0][0];
  assign out11imag = c_im[0][0];
  assign out12real = c_re[0][1];
  assign out12imag = c_im[0][1];
  assign out13real = c_re[0][2];
  assign out13imag = c_im[0][2];
  assign out14real = c_re[0][3];
  assign out14imag = c_im[0][3];
  assign out21real = c_re[1][0];
  assign out21imag = c_im[1][0];
  assign out22real = c_re[1][1];
  assign out22imag = c_im[1][1];
  assign out23real = c_re[1][2];
  assign out23imag = c_im[1][2];
  assign out24real = c_re[1][3];
  assign out24imag = c_im[1][3];
  assign out31real = c_re[2][0];
  assign out31imag = c_im[2][0];
  assign out32real = c_re[2][1];
  assign out32imag = c_im[2][1];
  assign out33real = c_re[2][2];
  assign out33imag = c_im[2][2];
  assign out34real = c_re[2][3];
  assign out34imag = c_im[2][3];
  assign out41real = c_re[3][0];
  assign out41imag = c_im[3][0];
  assign out42real = c_re[3][1];
  assign out42imag = c_im[3][1];
  assign out43real = c_re[3][2];
  assign out43imag = c_im[3][2];
  assign out44real = c_re[3][3];
  assign out44imag = c_im[3][3];
endmodule

// File: tb/tb_demux_filas_matriz_c.sv
// tb_demux_filas_matriz_c: directed checks of the C-matrix row collector
module tb_demux_filas_matriz_c;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic signed [7:0] o_re [4][4];
  logic signed [7:0] o_im [4][4];
  logic [1:0] row_cnt;
  logic busy, matrix_valid, done, err;
  int total = 0;
  int bad = 0;
  demux_filas_matriz_c_if #(.Width(8)) row ();
  demux_filas_matriz_c #(.Width(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .row(row),
    .out11real(o_re[0][0]), .out11imag(o_im[0][0]), .out12real(o_re[0][1]), .out12imag(o_im[0][1]),
    .out13real(o_re[0][2]), .out13imag(o_im[0][2]), .out14real(o_re[0][3]), .out14imag(o_im[0][3]),
    .out21real(o_re[1][0]), .out21imag(o_im[1][0]), .out22real(o_re[1][1]), .out22imag(o_im[1][1]),
    .out23real(o_re[1][2]), .out23imag(o_im[1][2]), .out24real(o_re[1][3]), .out24imag(o_im[1][3]),
    .out31real(o_re[2][0]), .out31imag(o_im[2][0]), .out32real(o_re[2][1]), .out32imag(o_im[2][1]),
    .out33real(o_re[2][2]), .out33imag(o_im[2][2]), .out34real(o_re[2][3]), .out34imag(o_im[2][3]),
    .out41real(o_re[3][0]), .out41imag(o_im[3][0]), .out42real(o_re[3][1]), .out42imag(o_im[3][1]),
    .out43real(o_re[3][2]), .out43imag(o_im[3][2]), .out44real(o_re[3][3]), .out44imag(o_im[3][3]),
    .row_cnt(row_cnt), .busy(busy), .matrix_valid(matrix_valid), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_row(input int idx, input int base);
    row.row_idx  = idx[1:0];
    row.inx1real = 8'(base + 1);
    row.inx1imag = 8'(-(base + 1));
    row.inx2real = 8'(base + 2);
    row.inx2imag = 8'(-(base + 2));
    row.inx3real = 8'(base + 3);
    row.inx3imag = 8'(-(base + 3));
    row.inx4real = 8'(base + 4);
    row.inx4imag = 8'(-(base + 4));
  endtask
  task automatic send_row(input int idx, input int base);
    set_row(idx, base);
    row.in_valid = 1'b1;
    step();
    row.in_valid = 1'b0;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic check_bank_zero(input string tag);
    int nz;
    nz = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (o_re[r][c] != 0 || o_im[r][c] != 0) nz++;
    check(tag, nz, 0);
  endtask
  initial begin
    int dones;
    row.in_valid = 1'b0;
    set_row(0, 0);
    #12;
    check("rst_in_ready", int'(row.in_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_mv", int'(matrix_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_cnt", int'(row_cnt), 0);
    check_bank_zero("rst_bank");
    rst_n = 1'b1;
    step();
    check("idle_ready", int'(row.in_ready), 0);
    pulse_start();
    check("fill_busy", int'(busy), 1);
    check("fill_ready", int'(row.in_ready), 1);
    for (int r = 0; r < 4; r++) begin
      send_row(r, 10 * (r + 1));
      check("fill_cnt", int'(row_cnt), (r + 1) % 4);
      check("fill_done", int'(done), r == 3 ? 1 : 0);
    end
    check("c23_re", int'(o_re[1][2]), 23);
    check("c23_im", int'(o_im[1][2]), -23);
    check("c44_re", int'(o_re[3][3]), 44);
    check("c11_im", int'(o_im[0][0]), -11);
    check("full_mv", int'(matrix_valid), 1);
    check("full_ready", int'(row.in_ready), 0);
    check("full_busy", int'(busy), 0);
    step();
    check("done_pulse", int'(done), 0);
    set_row(0, 90);
    row.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_done", int'(done), 0);
    end
    row.in_valid = 1'b0;
    check("hold_c23", int'(o_re[1][2]), 23);
    check("hold_c44", int'(o_re[3][3]), 44);
    check("hold_mv", int'(matrix_valid), 1);
    pulse_start();
    check("rearm_mv", int'(matrix_valid), 0);
    check("rearm_busy", int'(busy), 1);
    check_bank_zero("rearm_bank");
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      row.in_valid = (i % 2 == 0);
      set_row(i / 2, (i % 2 == 0) ? 10 * i : 100);
      step();
      dones += int'(done);
      check("tog_cnt", int'(row_cnt), ((i / 2) + 1) % 4);
    end
    row.in_valid = 1'b0;
    check("tog_dones", dones, 1);
    check("tog_r0", int'(o_re[0][0]), 1);
    check("tog_r1", int'(o_re[1][1]), 22);
    check("tog_r2", int'(o_im[2][3]), -44);
    check("tog_r3", int'(o_re[3][3]), 64);
    pulse_start();
    send_row(0, 30);
    send_row(1, 40);
    check("mid_cnt", int'(row_cnt), 2);
    set_row(2, 70);
    row.in_valid = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    row.in_valid = 1'b0;
    check_bank_zero("restart_bank");
    check("restart_cnt", int'(row_cnt), 0);
    check("restart_busy", int'(busy), 1);
    check("restart_mv", int'(matrix_valid), 0);
    send_row(0, 4);
    check("after_restart_r0", int'(o_re[0][0]), 5);
    check("after_restart_r2", int'(o_re[2][0]), 0);
    send_row(1, 14);
    send_row(2, 24);
    check("pre_rst_cnt", int'(row_cnt), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cnt", int'(row_cnt), 0);
    check("async_busy", int'(busy), 0);
    check("async_ready", int'(row.in_ready), 0);
    check_bank_zero("async_bank");
    #2;
    rst_n = 1'b1;
    set_row(3, 50);
    row.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    row.in_valid = 1'b0;
    check("post_rst_mv", int'(matrix_valid), 0);
    check("post_rst_cnt", int'(row_cnt), 0);
    pulse_start();
    for (int r = 0; r < 3; r++) send_row(r, r);
    check("partial_mv", int'(matrix_valid), 0);
    send_row(3, 3);
    check("refill_mv", int'(matrix_valid), 1);
`ifdef ROW_INDEX_CHECK_EN
    pulse_start();
    send_row(0, 10);
    send_row(2, 20);
    check("idx_err", int'(err), 1);
    check("idx_cnt", int'(row_cnt), 1);
    check("idx_skip", int'(o_re[1][0]), 0);
    send_row(1, 30);
    check("idx_ok_wr", int'(o_re[1][0]), 31);
    check("idx_ok_cnt", int'(row_cnt), 2);
    check("idx_sticky", int'(err), 1);
    pulse_start();
    check("idx_clear", int'(err), 0);
`else
    pulse_start();
    send_row(0, 10);
    send_row(2, 20);
    check("noidx_err", int'(err), 0);
    check("noidx_cnt", int'(row_cnt), 2);
    check("noidx_wr", int'(o_re[1][0]), 21);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
